// File: rtl/mdu.sv
// Multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU (and DIV/DIVU when built with MDU_DIV_EN) hold busy for a fixed
// number of cycles, then write HI/LO and pulse done. MTHI/MTLO finish in one cycle.
// Build option: define MDU_DIV_EN to include the divider; otherwise DIV/DIVU are no-ops.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic        done_reg, done_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic [31:0] a_reg, b_reg;
  logic        uns_reg;
  logic        load;
  logic        op_mul, op_div, op_mthi, op_mtlo;
  logic [31:0] res_hi, res_lo;
  logic [63:0] ext_a, ext_b, prod;

  assign op_mul  = (mdu_op[2:1] == 2'b00);
  assign op_mthi = (mdu_op == 3'b100);
  assign op_mtlo = (mdu_op == 3'b101);

`ifdef MDU_DIV_EN
  localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES - 1);
  logic        div_reg;
  logic [31:0] mag_a, mag_b, quo_mag, rem_mag;
  logic        neg_q, neg_r;

  assign op_div = (mdu_op[2:1] == 2'b01);

  // Remember whether the accepted operation is a divide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_reg <= 1'b0;
    else if (load) div_reg <= op_div;
  end

  // Divide on magnitudes, then restore signs; MIN/-1 falls out as MIN with remainder 0
  always_comb begin
    neg_q   = !uns_reg && (a_reg[31] ^ b_reg[31]);
    neg_r   = !uns_reg && a_reg[31];
    mag_a   = neg_r ? -a_reg : a_reg;
    mag_b   = (!uns_reg && b_reg[31]) ? -b_reg : b_reg;
    quo_mag = (mag_b == 32'd0) ? 32'd0 : mag_a / mag_b;
    rem_mag = (mag_b == 32'd0) ? 32'd0 : mag_a % mag_b;
  end
`else
  // Divider absent: DIV_CYCLES has no effect in this build
  logic [4:0] unused_div_cycles;
  assign unused_div_cycles = 5'(DIV_CYCLES);
  assign op_div = 1'b0;
`endif

  // Capture operands and signedness on the accepting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= 32'd0;
      b_reg   <= 32'd0;
      uns_reg <= 1'b0;
    end else if (load) begin
      a_reg   <= src_a;
      b_reg   <= src_b;
      uns_reg <= mdu_op[0];
    end
  end

  // Result of the latched operation; a sign/zero-extended 64-bit product covers both multiplies
  always_comb begin
    ext_a  = {(uns_reg ? 32'd0 : {32{a_reg[31]}}), a_reg};
    ext_b  = {(uns_reg ? 32'd0 : {32{b_reg[31]}}), b_reg};
    prod   = ext_a * ext_b;
    res_hi = prod[63:32];
    res_lo = prod[31:0];
`ifdef MDU_DIV_EN
    if (div_reg) begin
      if (b_reg == 32'd0) begin
        res_hi = a_reg;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = neg_r ? -rem_mag : rem_mag;
        res_lo = neg_q ? -quo_mag : quo_mag;
      end
    end
`endif
  end

  // Next-state: accept in IDLE, count down in RUN, cancel wins over completion
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (op_mul) begin
            state_next = RUN;
            cnt_next   = MULT_LOAD;
            load       = 1'b1;
          end else if (op_div) begin
            state_next = RUN;
`ifdef MDU_DIV_EN
            cnt_next   = DIV_LOAD;
`endif
            load       = 1'b1;
          end else if (op_mthi) begin
            hi_next = src_a;
          end else if (op_mtlo) begin
            lo_next = src_a;
          end
        end
      end
      RUN: begin
        if (cancel) begin
          state_next = IDLE;
          cnt_next   = 5'd0;
        end else if (cnt_reg == 5'd0) begin
          state_next = IDLE;
          done_next  = 1'b1;
          hi_next    = res_hi;
          lo_next    = res_lo;
        end else begin
          cnt_next = cnt_reg - 5'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counter, done pulse and HI/LO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 5'd0;
      done_reg  <= 1'b0;
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  assign busy = (state_reg == RUN);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_mdu.sv
// Testbench for mdu: directed cases plus randomized traffic against a
// transaction-level reference model (arithmetic results and cycle budget).
module tb_mdu;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
`ifdef MDU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  // reference model state
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [63:0] m_res = 64'd0;

  mdu #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mdu_op(mdu_op),
    .src_a(src_a), .src_b(src_b), .cancel(cancel),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // {hi, lo} an operation must produce, straight from the arithmetic rules
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    int          ia, ib;
    logic [63:0] p;
    case (op)
      3'd0: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
        return p;
      end
      3'd1: begin
        p = 64'(a) * 64'(b);
        return p;
      end
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        ia = a;
        ib = b;
        return {32'(ia % ib), 32'(ia / ib)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // One clock: drive inputs, advance the model across the edge, compare all outputs
  task automatic step(input logic s, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic c);
    start  = s;
    mdu_op = op;
    src_a  = a;
    src_b  = b;
    cancel = c;
    m_done = 1'b0;
    if (m_left > 0) begin
      if (c) m_left = 0;
      else if (m_left == 1) begin
        m_left = 0;
        {m_hi, m_lo} = m_res;
        m_done = 1'b1;
      end else m_left--;
    end else if (s) begin
      case (op)
        3'd0, 3'd1: begin
          m_left = MULT_CYCLES;
          m_res  = ref_result(op, a, b);
        end
        3'd2, 3'd3: if (DIV_ON) begin
          m_left = DIV_CYCLES;
          m_res  = ref_result(op, a, b);
        end
        3'd4: m_hi = a;
        3'd5: m_lo = a;
        default: ;
      endcase
    end
    @(negedge clk);
    start  = 1'b0;
    cancel = 1'b0;
    mdu_op = 3'($urandom);
    src_a  = $urandom;
    src_b  = $urandom;
    check("busy", 64'(busy), 64'(m_left > 0));
    check("done", 64'(done), 64'(m_done));
    check("hi", 64'(hi), 64'(m_hi));
    check("lo", 64'(lo), 64'(m_lo));
  endtask

  task automatic idle();
    step(1'b0, 3'($urandom), $urandom, $urandom, 1'b0);
  endtask

  task automatic run_to_done();
    for (int i = 0; i < 40 && !m_done; i++) idle();
  endtask

  // Asynchronous reset between edges; outputs must clear before the next edge
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    m_left = 0;
    m_done = 1'b0;
    m_hi   = 32'd0;
    m_lo   = 32'd0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] saved_hi;
    logic [31:0] saved_lo;
    logic [63:0] first_res;
    rst_n = 1'b0; start = 1'b0; cancel = 1'b0; mdu_op = 3'd0; src_a = 32'd0; src_b = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;

    // MULT -2 * 3, started on the first edge after reset release
    step(1'b1, 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    run_to_done();
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFFA);
    check("mult_done", 64'(done), 64'd1);
    idle();

    // DIV -7 / 2 and DIVU 7 / 0
    saved_hi = m_hi;
    saved_lo = m_lo;
    step(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    if (DIV_ON) begin
      run_to_done();
`ifdef MDU_DIV_EN
      check("div_lo", 64'(lo), 64'hFFFF_FFFD);
      check("div_hi", 64'(hi), 64'hFFFF_FFFF);
`endif
      idle();
      step(1'b1, 3'd3, 32'd7, 32'd0, 1'b0);
      run_to_done();
`ifdef MDU_DIV_EN
      check("divu0_hi", 64'(hi), 64'd7);
      check("divu0_lo", 64'(lo), 64'hFFFF_FFFF);
`endif
      idle();
    end else begin
      check("nodiv_busy", 64'(busy), 64'd0);
      check("nodiv_hi", 64'(hi), 64'(saved_hi));
      check("nodiv_lo", 64'(lo), 64'(saved_lo));
    end

    // start during busy is ignored; back-to-back start on the done cycle is accepted
    step(1'b1, 3'd1, 32'd100, 32'd200, 1'b0);
    first_res = ref_result(3'd1, 32'd100, 32'd200);
    step(1'b1, 3'd0, 32'h1111_1111, 32'h2222_2222, 1'b0);
    run_to_done();
    check("ign_hi", 64'(hi), 64'(first_res[63:32]));
    check("ign_lo", 64'(lo), 64'(first_res[31:0]));
    step(1'b1, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("b2b_busy", 64'(busy), 64'd1);
    run_to_done();
    idle();

    // MTLO then cancel MULTU in its third busy cycle
    step(1'b1, 3'd5, 32'h1234, 32'd0, 1'b0);
    step(1'b1, 3'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
    idle();
    idle();
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    check("cancel_busy", 64'(busy), 64'd0);
    check("cancel_lo", 64'(lo), 64'h1234);
    for (int i = 0; i < MULT_CYCLES; i++) idle();

    // reserved opcodes and cancel while idle
    step(1'b1, 3'd6, 32'hAAAA_AAAA, 32'd1, 1'b0);
    step(1'b1, 3'd7, 32'h5555_5555, 32'd1, 1'b1);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);

    // reset in the middle of a long operation
    step(1'b1, DIV_ON ? 3'd2 : 3'd0, 32'd1000, 32'd7, 1'b0);
    idle();
    idle();
    mid_reset();
    step(1'b1, 3'd4, 32'hCAFE_0001, 32'd0, 1'b0);

    // randomized traffic
    for (int n = 0; n < 2500; n++) begin
      step(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), pick(), pick(),
           ($urandom_range(0, 19) == 0));
      if (n % 600 == 599) mid_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL provide parameter MULT_CYCLES, default 5, meaning busy duration of MULT/MULTU in cycles (legal range 1..31).
REQ-002 SHALL provide parameter DIV_CYCLES, default 10, meaning busy duration of DIV/DIVU in cycles (legal range 1..31).
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port start  input  1  one-cycle request qualifying mdu_op/src_a/src_b.
REQ-006 SHALL provide port mdu_op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved (no-op).
REQ-007 SHALL provide port src_a  input  32  operand A (rs; MTHI/MTLO source).
REQ-008 SHALL provide port src_b  input  32  operand B (rt, or extended immediate from the EX operand mux).
REQ-009 SHALL provide port cancel  input  1  abort in-flight operation (EX flush).
REQ-010 SHALL provide port busy  output  1  operation in progress; pipeline stalls MFHI/MFLO/new MDU ops.
REQ-011 SHALL provide port done  output  1  one-cycle pulse: HI/LO just updated by MULT/DIV.
REQ-012 SHALL provide ports hi and lo  output  32 each  architectural HI/LO registers, registered outputs.

Function
REQ-013 SHALL implement FSM states IDLE and RUN; IDLE->RUN on accepted MULT/MULTU/DIV/DIVU; RUN->IDLE when counter expires or cancel=1.
REQ-014 SHALL accept start only when busy=0; start while busy=1 SHALL be ignored with no state change.
REQ-015 SHALL latch src_a, src_b and mdu_op at the accepting edge; later input changes SHALL not affect the result.
REQ-016 SHALL assert busy from the edge after acceptance for exactly MULT_CYCLES (multiply) or DIV_CYCLES (divide) cycles.
REQ-017 SHALL write HI/LO on the edge ending the last busy cycle and drive done=1 for exactly the following cycle with busy=0.
REQ-018 SHALL accept a new start in the cycle done=1 (back-to-back), restarting the counter.
REQ-019 SHALL compute MULT as signed 32x32->64 and MULTU as unsigned; HI=product[63:32], LO=product[31:0].
REQ-020 SHALL compute DIV signed, quotient truncated toward zero, remainder sign equal to dividend; LO=quotient, HI=remainder; DIVU unsigned.
REQ-021 SHALL on divisor zero write HI=src_a, LO=32'hFFFF_FFFF (signed and unsigned alike).
REQ-022 SHALL on DIV 32'h8000_0000 / 32'hFFFF_FFFF write LO=32'h8000_0000, HI=0.
REQ-023 SHALL execute MTHI/MTLO in one cycle when busy=0: hi/lo updated on the accepting edge, no busy, no done.
REQ-024 SHALL on cancel=1 in RUN return to IDLE next edge, leave HI/LO unchanged, emit no done; cancel in IDLE has no effect.
REQ-025 SHALL give cancel priority over completion when both occur on the same edge (HI/LO unchanged).
REQ-026 SHALL treat reserved opcodes as no-ops with no busy and no HI/LO change.

Reset
REQ-027 SHALL on rst_n=0 immediately force state IDLE, counter 0, busy=0, done=0, hi=0, lo=0, including mid-operation.
REQ-028 SHALL accept a start on the first rising edge after rst_n deasserts.

Configuration
REQ-029 SHALL, when macro MDU_DIV_EN is defined, implement DIV/DIVU as specified.
REQ-030 SHALL, when MDU_DIV_EN is undefined, remove divider logic and treat DIV/DIVU as reserved no-ops per REQ-026; DIV_CYCLES SHALL then be unused.

Verification
REQ-031 SHALL cover MULT src_a=32'hFFFF_FFFE (-2), src_b=3 -> busy 5 cycles, then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA, done one cycle.
REQ-032 SHALL cover DIV src_a=-7, src_b=2 -> busy 10 cycles, lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1); DIVU 7/0 -> hi=7, lo=32'hFFFF_FFFF.
REQ-033 SHALL cover start during busy with different operands -> ignored; result matches first operation; back-to-back start on done cycle accepted.
REQ-034 SHALL cover cancel in cycle 3 of MULTU after MTLO 32'h1234 -> busy low next cycle, no done, lo remains 32'h1234.
REQ-035 SHALL cover rst_n pulsed low mid-DIV -> busy, done, hi, lo all 0 immediately; build without MDU_DIV_EN -> DIV leaves HI/LO unchanged, busy stays 0.
